// File: rtl/a2bus_initiator.sv
// Apple II slot-bus initiator: runs a free-running 7-clock 6502 bus cycle on C7M and
// places queued host requests (read/write) onto the next cycle, idle cycles otherwise.
module a2bus_initiator #(
   parameter logic [2:0]  SLOT      = 3'd4,
   parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
   input  logic        C7M,
   input  logic        nRES,
   output logic        PHI1,
   output logic [15:0] A,
   output logic        nWE,
   inout  wire  [7:0]  D,
   output logic        nDEVSEL,
   output logic        nIOSEL,
   output logic        nIOSTRB,
   input  logic        nINH,
   input  logic        req,
   input  logic [15:0] addr,
   input  logic        wr,
   input  logic [7:0]  wdata,
   output logic        ack,
   output logic [7:0]  rdata,
   output logic        rinh,
   output logic        rvalid,
   output logic [15:0] cyc_cnt
);

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S3 = 3'd3;
   localparam logic [2:0] S4 = 3'd4;
   localparam logic [2:0] S5 = 3'd5;
   localparam logic [2:0] S7 = 3'd7;

   localparam logic [11:0] DEVSEL_HI = 12'hC08 + {9'd0, SLOT};
   localparam logic [7:0]  IOSEL_HI  = 8'hC0 + {5'd0, SLOT};
   localparam logic [4:0]  IOSTRB_HI = 5'b11001;

   logic [2:0]  state_q, state_d;
   logic [15:0] a_q, a_d;
   logic        we_n_q, we_n_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        act_q, act_d;
   logic        phi1_q, phi1_d;
   logic        devsel_n_q, devsel_n_d;
   logic        iosel_n_q, iosel_n_d;
   logic        iostrb_n_q, iostrb_n_d;
   logic        d_oe_q, d_oe_d;
   logic        ack_q, ack_d;
   logic        rvalid_q, rvalid_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        rinh_q, rinh_d;
   logic [15:0] cyc_cnt_q, cyc_cnt_d;
   logic        phi0_d;

   always_comb begin
      state_d    = (state_q == S7 || state_q == S0) ? S1 : state_q + 3'd1;
      a_d        = a_q;
      we_n_d     = we_n_q;
      wdata_d    = wdata_q;
      act_d      = act_q;
      ack_d      = 1'b0;
      cyc_cnt_d  = cyc_cnt_q;
      rvalid_d   = 1'b0;
      rdata_d    = rdata_q;
      rinh_d     = rinh_q;

      // Read data is captured as the cycle closes, so rvalid lands in the next S1.
      if (state_q == S7 && act_q && we_n_q) begin
         rvalid_d = 1'b1;
         rdata_d  = D;
         rinh_d   = ~nINH;
      end

      if (state_d == S1) begin
         cyc_cnt_d = cyc_cnt_q + 16'd1;
         if (req) begin
            a_d     = addr;
            we_n_d  = ~wr;
            wdata_d = wdata;
            act_d   = 1'b1;
            ack_d   = 1'b1;
         end else begin
            a_d     = IDLE_ADDR;
            we_n_d  = 1'b1;
            act_d   = 1'b0;
         end
      end

      // Selects never coincide with S1, so decoding the held address is safe here.
      phi0_d     = (state_d >= S4);
      phi1_d     = (state_d <= S3);
      devsel_n_d = ~(phi0_d && act_q && (a_q[15:4] == DEVSEL_HI));
      iosel_n_d  = ~(phi0_d && act_q && (a_q[15:8] == IOSEL_HI));
      iostrb_n_d = ~(phi0_d && act_q && (a_q[15:11] == IOSTRB_HI));
      d_oe_d     = act_q && !we_n_q && (state_d >= S5);
   end

   always_ff @(posedge C7M or negedge nRES) begin
      if (!nRES) begin
         state_q    <= S0;
         a_q        <= IDLE_ADDR;
         we_n_q     <= 1'b1;
         wdata_q    <= 8'h00;
         act_q      <= 1'b0;
         phi1_q     <= 1'b1;
         devsel_n_q <= 1'b1;
         iosel_n_q  <= 1'b1;
         iostrb_n_q <= 1'b1;
         d_oe_q     <= 1'b0;
         ack_q      <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 8'h00;
         rinh_q     <= 1'b0;
         cyc_cnt_q  <= 16'h0000;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         we_n_q     <= we_n_d;
         wdata_q    <= wdata_d;
         act_q      <= act_d;
         phi1_q     <= phi1_d;
         devsel_n_q <= devsel_n_d;
         iosel_n_q  <= iosel_n_d;
         iostrb_n_q <= iostrb_n_d;
         d_oe_q     <= d_oe_d;
         ack_q      <= ack_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rinh_q     <= rinh_d;
         cyc_cnt_q  <= cyc_cnt_d;
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_dbus
      assign D[gi] = d_oe_q ? wdata_q[gi] : 1'bz;
   end

   assign PHI1    = phi1_q;
   assign A       = a_q;
   assign nWE     = we_n_q;
   assign nDEVSEL = devsel_n_q;
   assign nIOSEL  = iosel_n_q;
   assign nIOSTRB = iostrb_n_q;
   assign ack     = ack_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rinh    = rinh_q;
   assign cyc_cnt = cyc_cnt_q;

endmodule
